// File: rtl/shift_normalizer.sv
// shift_normalizer: serial normalizer that shifts a word until its leading bit is set and reports the shift count.
// Optional feature macro NORMALIZER_DIR_EN adds in_dir to select right normalization (shift until LSB is 1).
module shift_normalizer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
`ifdef NORMALIZER_DIR_EN
   input  logic             in_dir,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_shift,
   output logic             out_zero
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             head;
   logic [WIDTH-1:0] shifted;
`ifdef NORMALIZER_DIR_EN
   logic             dir_q, dir_d;
   assign head    = dir_q ? word_q[0] : word_q[WIDTH-1];
   assign shifted = dir_q ? word_q >> 1 : word_q << 1;
`else
   assign head    = word_q[WIDTH-1];
   assign shifted = word_q << 1;
`endif
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign out_data  = word_q;
   assign out_shift = cnt_q;
   assign out_zero  = zero_q;
   // next-state: accept in IDLE, shift one position per cycle in SHIFT, hold result in DONE
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
`ifdef NORMALIZER_DIR_EN
      dir_d   = dir_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            word_d  = in_data;
            cnt_d   = '0;
            zero_d  = 1'b0;
`ifdef NORMALIZER_DIR_EN
            dir_d   = in_dir;
`endif
            state_d = SHIFT;
         end
         SHIFT: if (word_q == '0) begin
            zero_d  = 1'b1;
            cnt_d   = '0;
            word_d  = '0;
            state_d = DONE;
         end else if (head) begin
            state_d = DONE;
         end else begin
            word_d  = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
`ifdef NORMALIZER_DIR_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
`ifdef NORMALIZER_DIR_EN
         dir_q   <= dir_d;
`endif
      end
   end
endmodule
